// File: rtl/power_gesture_ctrl.sv
// Hood power controller: power button (instant on, long-press off), left/right wave
// gestures inside an editable window, and live editing of that window in seconds.
module power_gesture_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int HOLD_OFF_S = 3,
  parameter int GEST_DEF_S = 5,
  parameter int GEST_MIN_S = 1,
  parameter int GEST_MAX_S = 59,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int SEC_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on_off_btn,
  input  logic             left_btn,
  input  logic             right_btn,
  input  logic             gesture_en,
  input  logic [3:0]       edit_btn,
  output logic             power_on,
  output logic             power_evt,
  output logic [SEC_W-1:0] gesture_s,
  output logic             edit_mode,
  output logic             edit_digit,
  output logic [1:0]       gest_state,
  output logic [SEC_W-1:0] gest_remain_s
);

  localparam int HOLD_CYC = HOLD_OFF_S * CLK_HZ;
  localparam int HOLD_W   = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [SEC_W:0] MIN_X = (SEC_W+1)'(GEST_MIN_S);
  localparam logic [SEC_W:0] MAX_X = (SEC_W+1)'(GEST_MAX_S);

  typedef enum logic [1:0] {
    G_IDLE  = 2'b00,
    G_ARM_L = 2'b01,
    G_ARM_R = 2'b10,
    G_LOCK  = 2'b11
  } gest_t;

  gest_t             state_q, state_d;
  logic              power_q, power_d, evt_q, evt_d;
  logic [SEC_W-1:0]  gest_s_q, gest_s_d, remain_q, remain_d;
  logic              edit_mode_q, edit_mode_d, edit_digit_q, edit_digit_d;
  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              lock_q, lock_d;
  logic              btn_prev_q, btn_prev_d, left_prev_q, left_prev_d, right_prev_q, right_prev_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]        samp_q, samp_d, edge_q, edge_d;

  logic btn_rise, left_rise, right_rise, deb_tick, presc_wrap, timeout;
  logic btn_on, btn_off, g_on, g_off;
  logic [SEC_W:0] step, sum;

  always_comb begin
    btn_rise   = on_off_btn & ~btn_prev_q;
    left_rise  = left_btn & ~left_prev_q;
    right_rise = right_btn & ~right_prev_q;
    btn_prev_d   = on_off_btn;
    left_prev_d  = left_btn;
    right_prev_d = right_btn;

    // Edit buttons are raw: look at them only once per DEB_CYCLES.
    deb_tick  = (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));
    deb_cnt_d = deb_tick ? '0 : deb_cnt_q + 1'b1;
    samp_d    = deb_tick ? edit_btn : samp_q;
    edge_d    = deb_tick ? (edit_btn & ~samp_q) : 4'b0000;

    lock_d  = lock_q;
    hold_d  = hold_q;
    btn_on  = 1'b0;
    btn_off = 1'b0;
    if (!on_off_btn) begin
      lock_d = 1'b0;
      hold_d = '0;
    end else if (!power_q) begin
      hold_d = '0;
      if (btn_rise && !lock_q) begin
        btn_on = 1'b1;
        lock_d = 1'b1;
      end
    end else if (!lock_q) begin
      if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
        btn_off = 1'b1;
        lock_d  = 1'b1;
        hold_d  = '0;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end

    state_d    = state_q;
    remain_d   = remain_q;
    presc_d    = presc_q;
    g_on       = 1'b0;
    g_off      = 1'b0;
    presc_wrap = (presc_q == PRE_W'(CLK_HZ - 1));
    timeout    = presc_wrap && (remain_q == SEC_W'(1));
    if (!gesture_en) begin
      state_d  = G_IDLE;
      remain_d = '0;
      presc_d  = '0;
    end else begin
      case (state_q)
        G_IDLE: begin
          if (left_rise && !right_btn) begin
            state_d  = G_ARM_L;
            remain_d = gest_s_q;
            presc_d  = '0;
          end else if (right_rise && !left_btn) begin
            state_d  = G_ARM_R;
            remain_d = gest_s_q;
            presc_d  = '0;
          end
        end
        G_ARM_L, G_ARM_R: begin
          presc_d = presc_wrap ? '0 : presc_q + 1'b1;
          // Expiry wins over a same-edge completion so the window is exact.
          if (timeout) begin
            state_d  = G_IDLE;
            remain_d = '0;
          end else if ((state_q == G_ARM_L) ? right_rise : left_rise) begin
            state_d  = G_LOCK;
            remain_d = '0;
            presc_d  = '0;
            g_on     = (state_q == G_ARM_L);
            g_off    = (state_q == G_ARM_R);
          end else if ((state_q == G_ARM_L) ? left_rise : right_rise) begin
            remain_d = gest_s_q;
            presc_d  = '0;
          end else if (presc_wrap) begin
            remain_d = remain_q - 1'b1;
          end
        end
        default: begin
          if (!left_btn && !right_btn) state_d = G_IDLE;
        end
      endcase
    end

    power_d = power_q;
    if (btn_on)       power_d = 1'b1;
    else if (btn_off) power_d = 1'b0;
    else if (g_on)    power_d = 1'b1;
    else if (g_off)   power_d = 1'b0;
    evt_d = (power_d != power_q);

    edit_mode_d  = edit_mode_q;
    edit_digit_d = edit_digit_q;
    gest_s_d     = gest_s_q;
    step         = edit_digit_q ? (SEC_W+1)'(10) : (SEC_W+1)'(1);
    sum          = {1'b0, gest_s_q} + step;
    if ($onehot(edge_q)) begin
      if (edge_q[3] && power_q) edit_mode_d = ~edit_mode_q;
      if (edit_mode_q) begin
        if (edge_q[0]) edit_digit_d = ~edit_digit_q;
        if (edge_q[2]) gest_s_d = (sum > MAX_X) ? MIN_X[SEC_W-1:0] : sum[SEC_W-1:0];
        if (edge_q[1]) gest_s_d = ({1'b0, gest_s_q} < (step + MIN_X)) ? MAX_X[SEC_W-1:0]
                                                                       : gest_s_q - step[SEC_W-1:0];
      end
    end
    if (!power_d) begin
      edit_mode_d  = 1'b0;
      edit_digit_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= G_IDLE;
      power_q      <= 1'b0;
      evt_q        <= 1'b0;
      gest_s_q     <= SEC_W'(GEST_DEF_S);
      remain_q     <= '0;
      edit_mode_q  <= 1'b0;
      edit_digit_q <= 1'b0;
      presc_q      <= '0;
      hold_q       <= '0;
      lock_q       <= 1'b0;
      btn_prev_q   <= 1'b0;
      left_prev_q  <= 1'b0;
      right_prev_q <= 1'b0;
      deb_cnt_q    <= '0;
      samp_q       <= 4'b0000;
      edge_q       <= 4'b0000;
    end else begin
      state_q      <= state_d;
      power_q      <= power_d;
      evt_q        <= evt_d;
      gest_s_q     <= gest_s_d;
      remain_q     <= remain_d;
      edit_mode_q  <= edit_mode_d;
      edit_digit_q <= edit_digit_d;
      presc_q      <= presc_d;
      hold_q       <= hold_d;
      lock_q       <= lock_d;
      btn_prev_q   <= btn_prev_d;
      left_prev_q  <= left_prev_d;
      right_prev_q <= right_prev_d;
      deb_cnt_q    <= deb_cnt_d;
      samp_q       <= samp_d;
      edge_q       <= edge_d;
    end
  end

  assign power_on      = power_q;
  assign power_evt     = evt_q;
  assign gesture_s     = gest_s_q;
  assign edit_mode     = edit_mode_q;
  assign edit_digit    = edit_digit_q;
  assign gest_state    = state_q;
  assign gest_remain_s = remain_q;

endmodule
